// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the BCD mm:ss timer counter.
package bcd_timer_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Even digits count 0-9 (units), odd digits 0-5 (tens of seconds/minutes).
  function automatic logic [DIGIT_W-1:0] digit_max(input int unsigned i);
    return ((i % 2) == 0) ? DIGIT_W'(9) : DIGIT_W'(5);
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit register with clamp-on-load and inc/dec carry/borrow ripple.
module bcd_digit_cell
  import bcd_timer_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = DIGIT_W'(9)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_digit,
  input  logic               cin,
  input  logic               bin,
  output logic               cout,
  output logic               bout,
  output logic [DIGIT_W-1:0] digit,
  output logic               is_zero,
  output logic               is_max
);

  logic [DIGIT_W-1:0] load_clamped;

  assign is_zero      = (digit == '0);
  assign is_max       = (digit == MAX);
  assign cout         = cin & is_max;
  assign bout         = bin & is_zero;
  assign load_clamped = (load_digit > MAX) ? MAX : load_digit;

  always_ff @(posedge clk) begin
    if (rst) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (load) begin
      digit <= load_clamped;
    end else if (cin) begin
      digit <= is_max ? '0 : digit + DIGIT_W'(1);
    end else if (bin) begin
      digit <= is_zero ? MAX : digit - DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/bcd_timer_counter.sv
// BCD up/down mm:ss timer with run/stop FSM, wrap pulse and prefix zero/top flags.
// Define BCD_TIMER_SAT_EN for the saturating build (no wrap, sticky done).
module bcd_timer_counter
  import bcd_timer_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter bit          START_RUN  = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic                          start,
  input  logic                          up_dn,
  input  logic                          clr,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] load_val,
  output logic [DIGIT_W*NUM_DIGITS-1:0] count,
  output logic [NUM_DIGITS-1:0]         zero,
  output logic [NUM_DIGITS-1:0]         top,
  output logic                          running,
  output logic                          wrap,
  output logic                          done
);

  state_t                state, state_nxt;
  logic                  step, terminal, cnt_en;
  logic [NUM_DIGITS:0]   carry, borrow;
  logic [NUM_DIGITS-1:0] dig_zero, dig_max;

  // A tick only counts in RUN when no higher-priority control is present.
  assign step     = (state == RUN) & tick & ~clr & ~load & ~start;
  assign terminal = up_dn ? top[NUM_DIGITS-1] : zero[NUM_DIGITS-1];
  assign running  = (state == RUN);

`ifdef BCD_TIMER_SAT_EN
  logic done_q;

  assign cnt_en = step & ~terminal;
  assign wrap   = 1'b0;
  assign done   = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
    end else if (clr | load) begin
      done_q <= 1'b0;
    end else if (step & terminal) begin
      done_q <= 1'b1;
    end
  end
`else
  logic wrap_q;

  assign cnt_en = step;
  assign wrap   = wrap_q;
  assign done   = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= step & terminal;
    end
  end
`endif

  assign carry[0]  = cnt_en & up_dn;
  assign borrow[0] = cnt_en & ~up_dn;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit_cell #(
      .MAX(digit_max(i))
    ) u_cell (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .load      (load),
      .load_digit(load_val[DIGIT_W*i +: DIGIT_W]),
      .cin       (carry[i]),
      .bin       (borrow[i]),
      .cout      (carry[i+1]),
      .bout      (borrow[i+1]),
      .digit     (count[DIGIT_W*i +: DIGIT_W]),
      .is_zero   (dig_zero[i]),
      .is_max    (dig_max[i])
    );

    if (i == 0) begin : g_first
      assign zero[i] = dig_zero[i];
      assign top[i]  = dig_max[i];
    end else begin : g_chain
      assign zero[i] = zero[i-1] & dig_zero[i];
      assign top[i]  = top[i-1] & dig_max[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= START_RUN ? RUN : STOP;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clr | load) begin
      if (state == DONE) state_nxt = STOP;
    end else if (start) begin
      if (state == STOP)     state_nxt = RUN;
      else if (state == RUN) state_nxt = STOP;
    end
`ifdef BCD_TIMER_SAT_EN
    else if (step & terminal) begin
      state_nxt = DONE;
    end
`endif
  end

endmodule

// File: tb/tb_bcd_timer_counter.sv
// Randomized and directed bench for bcd_timer_counter against a mixed-radix integer model.
module tb_bcd_timer_counter;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b0, tick = 1'b0, start = 1'b0, up_dn = 1'b1;
  logic         clr = 1'b0, load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count;
  logic [N-1:0] zero, top;
  logic         running, wrap, done;

  int n_tests = 0;
  int n_fail  = 0;

  // model: count as an integer in [0, modulus), state 0=stop 1=run 2=done
  int m_val = 0;
  int m_state = 0;
  bit m_wrap = 0;
  bit m_done = 0;

  always #5 clk = ~clk;

  bcd_timer_counter #(.NUM_DIGITS(N), .START_RUN(1'b0)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .up_dn(up_dn),
    .clr(clr), .load(load), .load_val(load_val), .count(count),
    .zero(zero), .top(top), .running(running), .wrap(wrap), .done(done)
  );

  function automatic int radix(input int i);
    return (i % 2) ? 6 : 10;
  endfunction

  function automatic int modulus();
    int m = 1;
    for (int i = 0; i < N; i++) m = m * radix(i);
    return m;
  endfunction

  function automatic int to_int(input logic [W-1:0] lv);
    int v = 0;
    int d;
    for (int i = N - 1; i >= 0; i--) begin
      d = int'(lv[4*i +: 4]);
      if (d > radix(i) - 1) d = radix(i) - 1;
      v = v * radix(i) + d;
    end
    return v;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r = '0;
    int x = v;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(x % radix(i));
      x = x / radix(i);
    end
    return r;
  endfunction

  function automatic logic [N-1:0] exp_zero(input int v);
    logic [N-1:0] z = '0;
    int p = 1;
    for (int k = 0; k < N; k++) begin
      p = p * radix(k);
      z[k] = ((v % p) == 0);
    end
    return z;
  endfunction

  function automatic logic [N-1:0] exp_top(input int v);
    logic [N-1:0] t = '0;
    int p = 1;
    for (int k = 0; k < N; k++) begin
      p = p * radix(k);
      t[k] = ((v % p) == p - 1);
    end
    return t;
  endfunction

  task automatic model_edge();
    int m = modulus();
    if (rst) begin
      m_val = 0; m_state = 0; m_wrap = 0; m_done = 0;
    end else begin
      m_wrap = 0;
      if (clr) begin
        m_val = 0; m_done = 0;
        if (m_state == 2) m_state = 0;
      end else if (load) begin
        m_val = to_int(load_val); m_done = 0;
        if (m_state == 2) m_state = 0;
      end else if (start) begin
        if (m_state == 0) m_state = 1;
        else if (m_state == 1) m_state = 0;
      end else if (tick && m_state == 1) begin
        if ((up_dn && m_val == m - 1) || (!up_dn && m_val == 0)) begin
`ifdef BCD_TIMER_SAT_EN
          m_done = 1; m_state = 2;
`else
          m_val = up_dn ? 0 : m - 1; m_wrap = 1;
`endif
        end else begin
          m_val = up_dn ? m_val + 1 : m_val - 1;
        end
      end
    end
  endtask

  // Drive one cycle of inputs at negedge, update the model at posedge, return at next negedge.
  task automatic cyc(input logic r, input logic cl, input logic ld, input logic [W-1:0] lv,
                     input logic st, input logic tk, input logic ud);
    rst = r; clr = cl; load = ld; load_val = lv; start = st; tick = tk; up_dn = ud;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    rst = 0; clr = 0; load = 0; start = 0; tick = 0;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, '0, 0, 0, 1);
    n_tests++;
    if (count !== 16'h0000 || zero !== 4'b1111 || top !== 4'b0000 ||
        running !== 1'b0 || wrap !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: count=%h zero=%b top=%b run=%b wrap=%b done=%b, want 0000 1111 0000 0 0 0",
               count, zero, top, running, wrap, done);
    end
  endtask

  task automatic test_count_up();
    cyc(1, 0, 0, '0, 0, 0, 1);
    cyc(0, 0, 0, '0, 1, 0, 1);
    n_tests++;
    if (running !== 1'b1) begin
      n_fail++;
      $display("FAIL start_run: running=%b want 1", running);
    end
    for (int i = 0; i < 59; i++) cyc(0, 0, 0, '0, 0, 1, 1);
    n_tests++;
    if (count !== 16'h0059 || top[1:0] !== 2'b11 || top[3:2] !== 2'b00) begin
      n_fail++;
      $display("FAIL up_0059: count=%h top=%b want 0059 0011", count, top);
    end
    cyc(0, 0, 0, '0, 0, 1, 1);
    n_tests++;
    if (count !== 16'h0100 || zero[1:0] !== 2'b11 || zero[2] !== 1'b0 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL up_0100: count=%h zero=%b wrap=%b want 0100 0011 0", count, zero, wrap);
    end
  endtask

`ifndef BCD_TIMER_SAT_EN
  task automatic test_wrap_up();
    cyc(1, 0, 0, '0, 0, 0, 1);
    cyc(0, 0, 1, 16'h5959, 0, 0, 1);
    cyc(0, 0, 0, '0, 1, 0, 1);
    cyc(0, 0, 0, '0, 0, 1, 1);
    n_tests++;
    if (count !== 16'h0000 || wrap !== 1'b1 || zero !== 4'b1111) begin
      n_fail++;
      $display("FAIL wrap_up: count=%h wrap=%b zero=%b want 0000 1 1111", count, wrap, zero);
    end
    cyc(0, 0, 0, '0, 0, 0, 1);
    n_tests++;
    if (wrap !== 1'b0 || count !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_pulse: wrap=%b count=%h want 0 0000", wrap, count);
    end
  endtask

  task automatic test_wrap_down();
    cyc(1, 0, 0, '0, 0, 0, 0);
    cyc(0, 0, 1, 16'h0000, 0, 0, 0);
    cyc(0, 0, 0, '0, 1, 0, 0);
    cyc(0, 0, 0, '0, 0, 1, 0);
    n_tests++;
    if (count !== 16'h5959 || wrap !== 1'b1 || top !== 4'b1111) begin
      n_fail++;
      $display("FAIL wrap_down: count=%h wrap=%b top=%b want 5959 1 1111", count, wrap, top);
    end
  endtask
`else
  task automatic test_saturate();
    cyc(1, 0, 0, '0, 0, 0, 0);
    cyc(0, 0, 1, 16'h0001, 0, 0, 0);
    cyc(0, 0, 0, '0, 1, 0, 0);
    cyc(0, 0, 0, '0, 0, 1, 0);
    n_tests++;
    if (count !== 16'h0000 || done !== 1'b0 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_first: count=%h done=%b run=%b want 0000 0 1", count, done, running);
    end
    cyc(0, 0, 0, '0, 0, 1, 0);
    n_tests++;
    if (count !== 16'h0000 || done !== 1'b1 || running !== 1'b0 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_done: count=%h done=%b run=%b wrap=%b want 0000 1 0 0",
               count, done, running, wrap);
    end
    cyc(0, 0, 0, '0, 0, 1, 0);
    n_tests++;
    if (count !== 16'h0000 || done !== 1'b1 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_hold: count=%h done=%b wrap=%b want 0000 1 0", count, done, wrap);
    end
    cyc(0, 0, 1, 16'h0030, 0, 0, 0);
    cyc(0, 0, 0, '0, 0, 1, 0);
    n_tests++;
    if (count !== 16'h0030 || done !== 1'b0 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_reload: count=%h done=%b run=%b want 0030 0 0", count, done, running);
    end
  endtask
`endif

  task automatic test_load_clamp_clr();
    cyc(1, 0, 0, '0, 0, 0, 1);
    cyc(0, 0, 1, 16'hFFFF, 0, 0, 1);
    n_tests++;
    if (count !== 16'h5959 || top !== 4'b1111) begin
      n_fail++;
      $display("FAIL load_clamp: count=%h top=%b want 5959 1111", count, top);
    end
    cyc(0, 0, 1, 16'hC7A3, 0, 0, 1);
    n_tests++;
    if (count !== 16'h5753) begin
      n_fail++;
      $display("FAIL load_mixed: count=%h want 5753", count);
    end
    cyc(0, 1, 0, '0, 0, 0, 1);
    n_tests++;
    if (count !== 16'h0000 || zero !== 4'b1111) begin
      n_fail++;
      $display("FAIL clr: count=%h zero=%b want 0000 1111", count, zero);
    end
  endtask

  task automatic test_start_tick();
    cyc(1, 0, 0, '0, 0, 0, 1);
    cyc(0, 0, 0, '0, 1, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, '0, 0, 1, 1);
    cyc(0, 0, 0, '0, 1, 1, 1);
    n_tests++;
    if (running !== 1'b0 || count !== 16'h0005) begin
      n_fail++;
      $display("FAIL start_tick: run=%b count=%h want 0 0005", running, count);
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, '0, 0, 1, 1);
    n_tests++;
    if (count !== 16'h0005 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_ignore: count=%h run=%b want 0005 0", count, running);
    end
    cyc(0, 0, 1, 16'h0042, 0, 1, 1);
    n_tests++;
    if (count !== 16'h0042) begin
      n_fail++;
      $display("FAIL load_vs_tick: count=%h want 0042", count);
    end
  endtask

  task automatic test_random();
    logic         r, cl, ld, st, tk, ud;
    logic [W-1:0] lv;
    cyc(1, 0, 0, '0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      cl = ($urandom_range(0, 63) == 0);
      ld = ($urandom_range(0, 31) == 0);
      st = ($urandom_range(0, 15) == 0);
      tk = ($urandom_range(0, 1) == 1);
      ud = ($urandom_range(0, 9) < 6);
      lv = W'($urandom);
      // bias some loads to sit just below a terminal count
      if ($urandom_range(0, 1) == 1) lv = ud ? 16'h5958 : 16'h0001;
      cyc(r, cl, ld, lv, st, tk, ud);
      n_tests++;
      if (count !== to_bcd(m_val) || zero !== exp_zero(m_val) || top !== exp_top(m_val) ||
          running !== (m_state == 1) || wrap !== m_wrap || done !== m_done) begin
        n_fail++;
        $display("FAIL random[%0d]: count=%h zero=%b top=%b run=%b wrap=%b done=%b, want %h %b %b %b %b %b",
                 i, count, zero, top, running, wrap, done, to_bcd(m_val), exp_zero(m_val),
                 exp_top(m_val), (m_state == 1), m_wrap, m_done);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_count_up();
`ifndef BCD_TIMER_SAT_EN
    test_wrap_up();
    test_wrap_down();
`else
    test_saturate();
`endif
    test_load_clamp_clr();
    test_start_tick();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
